cache_mem_arbiter: RTL

//  Shares the single RAM port between the icache and the dcache miss paths; sits between both caches and ram.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/cache_mem_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU bus types: word, RAM handshake state and the
//            cache/RAM arbiter state encoding.
// Revision : 1.0
// ============================================================================
package cpu_types_pkg;

    localparam int c_WORD_W = 32;

    typedef logic [c_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t c_ARB_IDLE  = 2'd0;
    localparam arb_state_t c_ARB_DSERV = 2'd1;
    localparam arb_state_t c_ARB_ISERV = 2'd2;
    localparam arb_state_t c_ARB_DONE  = 2'd3;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Shares one RAM port between icache and dcache miss paths, one
//            transaction at a time, with a sticky service-hang watchdog.
//            Define ARB_RR_EN for round-robin on simultaneous requests
//            (default: fixed dcache priority).
// Revision : 1.0
// ============================================================================
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = c_WORD_W,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              err_timeout
);

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    arb_state_t        r_state;
    logic              r_is_d;
    logic              r_wen;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;
    logic [WORD_W-1:0] r_iload;
    logic [WORD_W-1:0] r_dload;
    logic [15:0]       r_cnt;
    logic              r_err;

    logic              w_dreq;
    logic              w_req;
    logic              w_grant_d;
    logic              w_serv;
    logic              w_done;
    logic              w_access;
    logic [15:0]       w_cnt_nxt;

    assign w_dreq   = dREN | dWEN;
    assign w_req    = w_dreq | iREN;
    assign w_serv   = (r_state == c_ARB_DSERV) || (r_state == c_ARB_ISERV);
    assign w_done   = (r_state == c_ARB_DONE);
    assign w_access = (ramstate == RAM_ACCESS);
    assign w_cnt_nxt = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

`ifdef ARB_RR_EN
    // High when the dcache won the most recent arbitration.
    logic r_last_d;

    assign w_grant_d = w_dreq & (~iREN | ~r_last_d);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_d <= 1'b0;
        end else if ((r_state == c_ARB_IDLE) && w_req) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_dreq;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ARB_IDLE;
            r_is_d  <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_iload <= '0;
            r_dload <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ARB_IDLE: begin
                    if (w_req) begin
                        r_state <= w_grant_d ? c_ARB_DSERV : c_ARB_ISERV;
                        r_is_d  <= w_grant_d;
                        r_wen   <= w_grant_d & dWEN;
                        r_addr  <= w_grant_d ? daddr : iaddr;
                        r_data  <= (w_grant_d & dWEN) ? dstore : '0;
                        r_cnt   <= '0;
                    end
                end
                c_ARB_DSERV, c_ARB_ISERV: begin
                    if (w_access) begin
                        // Writes return nothing useful; keep the last read value.
                        if (!r_wen) begin
                            if (r_is_d) begin
                                r_dload <= ramload;
                            end else begin
                                r_iload <= ramload;
                            end
                        end
                        r_state <= c_ARB_DONE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt >= c_TIMEOUT) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ARB_DONE: begin
                    r_state <= c_ARB_IDLE;
                end
                default: begin
                    r_state <= c_ARB_IDLE;
                end
            endcase
        end
    end

    assign ramREN      = w_serv & ~r_wen;
    assign ramWEN      = w_serv &  r_wen;
    assign ramaddr     = w_serv ? r_addr : '0;
    assign ramstore    = w_serv ? r_data : '0;

    assign iwait       = ~(w_done & ~r_is_d);
    assign dwait       = ~(w_done &  r_is_d);
    assign iload       = r_iload;
    assign dload       = r_dload;
    assign err_timeout = r_err;

endmodule
`default_nettype wire
